instr_mem_ctrl: RTL and testbench

Parametrised, clocked instruction memory for the fetch stage: word-organised, big-endian byte-addressed storage. Fetch uses a valid/ready request/response handshake with a one-entry registered output. A separate loader port, driven by the boot/debug path, writes program words with byte enables. On every reset the block clears the whole array with a hardware sequencer, then reports init_done. Misaligned or out-of-range fetches return a fault code instead of garbage.

---
 rtl/instr_mem_pkg.sv | 38 +++
 rtl/instr_mem_ctrl_if.sv | 54 +++++
 rtl/instr_mem_array.sv | 56 +++++
 rtl/instr_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pkg
// Description : Shared constants for the fetch-stage instruction memory:
//               response fault codes, controller state encoding, default
//               NOP word and a per-byte even-parity helper.
// Options     : IMEM_PARITY_EN (parity helper only used when defined)
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

   // Response fault codes
   localparam logic [1:0] FAULT_OK       = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;
   localparam logic [1:0] FAULT_PARITY   = 2'b11;

   // Controller state encoding
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Instruction word returned with faulted responses unless overridden
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   // Even parity per byte: bit b is the XOR of byte b, so byte plus parity
   // always carries an even number of ones.
   function automatic logic [3:0] byte_parity(input logic [31:0] word);
      logic [3:0] par;
      for (int b = 0; b < 4; b++) begin
         par[b] = ^word[8*b +: 8];
      end
      return par;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl_if
// Description : Fetch request/response and loader write bundle of the
//               instruction memory.
//               master : fetch unit / boot loader side
//               slave  : instr_mem_ctrl side
// Ports       : init_done, req_*, resp_*, ld_*, inj_par_err (option only)
// Options     : IMEM_PARITY_EN adds inj_par_err
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              init_done;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_instr;
   logic [1:0]        resp_fault;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [3:0]        ld_be;
   logic [31:0]       ld_data;
   logic              ld_err;
`ifdef IMEM_PARITY_EN
   logic              inj_par_err;
`endif

   modport master (
`ifdef IMEM_PARITY_EN
      output inj_par_err,
`endif
      output req_valid, req_addr, resp_ready,
      output ld_valid, ld_addr, ld_be, ld_data,
      input  init_done, req_ready, resp_valid, resp_instr, resp_fault,
      input  ld_ready, ld_err
   );

   modport slave (
`ifdef IMEM_PARITY_EN
      input  inj_par_err,
`endif
      input  req_valid, req_addr, resp_ready,
      input  ld_valid, ld_addr, ld_be, ld_data,
      output init_done, req_ready, resp_valid, resp_instr, resp_fault,
      output ld_ready, ld_err
   );

endinterface
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_array
// Description : Word array with one clocked byte-enabled write port and one
//               combinational read port. A read and a write to the same word
//               in the same cycle return the old contents.
// Ports       : clk            - clock
//               we/waddr/wbe/wdata - write port, wbe[b] -> bits 8b+7:8b
//               wpar           - per-byte parity to store (option only)
//               raddr/rdata    - read port
//               rpar           - stored parity of the read word (option only)
// Options     : IMEM_PARITY_EN stores one parity bit per byte
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
   parameter int DEPTH_WORDS = 64,
   localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [3:0]       wbe,
   input  logic [31:0]      wdata,
`ifdef IMEM_PARITY_EN
   input  logic [3:0]       wpar,
   output logic [3:0]       rpar,
`endif
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
   logic [3:0]  par_mem [DEPTH_WORDS];
`endif

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
`ifdef IMEM_PARITY_EN
               par_mem[waddr][b]    <= wpar[b];
`endif
            end
         end
      end
   end

   assign rdata = mem[raddr];
`ifdef IMEM_PARITY_EN
   assign rpar  = par_mem[raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl
// Description : Fetch-stage instruction memory. Big-endian byte addressing
//               (byte[addr] in bits 31:24), valid/ready fetch with a one-entry
//               response register, byte-enabled loader port, and a hardware
//               clear of the whole array after every reset.
// Ports       : clk   - clock, all state on rising edge
//               reset - asynchronous, active-low reset
//               bus   - instr_mem_ctrl_if.slave (fetch, response, loader,
//                       init_done, ld_err)
// Options     : IMEM_PARITY_EN - per-byte even parity, fault 11, inj_par_err
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter int          ADDR_W      = 32,
   parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   instr_mem_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   // Clear counter has one extra bit: it runs 0..DEPTH_WORDS, writing while
   // the top bit is clear and leaving CLEAR once it reaches DEPTH_WORDS. That
   // extra count is the one-cycle entry into CLEAR before init_done.
   localparam logic [IDX_W:0] CLR_LAST = (IDX_W+1)'(DEPTH_WORDS);

   state_t           state, state_nxt;
   logic [IDX_W:0]   clr_cnt, clr_cnt_nxt;
   logic             run;

   logic             resp_valid_q;
   logic [31:0]      resp_instr_q;
   logic [1:0]       resp_fault_q;
   logic             ld_err_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // ---------------- next state / status outputs ----------------
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      run         = 1'b0;
      case (state)
         ST_CLEAR: begin
            if (clr_cnt == CLR_LAST) state_nxt   = ST_RUN;
            else                     clr_cnt_nxt = clr_cnt + 1'b1;
         end
         ST_RUN: begin
            run = 1'b1;
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   // ---------------- address decode ----------------
   // Range check looks at every address bit above the word index, so no
   // high address aliases onto a valid word.
   logic             req_misalign, req_range;
   logic             ld_misalign, ld_range, ld_ok, ld_fire, req_fire;
   logic [IDX_W-1:0] req_idx, ld_idx;

   assign req_misalign = |bus.req_addr[1:0];
   assign req_range    = |bus.req_addr[ADDR_W-1:IDX_W+2];
   assign req_idx      = bus.req_addr[IDX_W+1:2];
   assign ld_misalign  = |bus.ld_addr[1:0];
   assign ld_range     = |bus.ld_addr[ADDR_W-1:IDX_W+2];
   assign ld_idx       = bus.ld_addr[IDX_W+1:2];

   assign ld_ok    = !ld_misalign && !ld_range;
   assign ld_fire  = bus.ld_valid && run;
   assign req_fire = bus.req_valid && bus.req_ready;

   // ---------------- array ----------------
   logic             arr_we;
   logic [IDX_W-1:0] arr_waddr;
   logic [3:0]       arr_wbe;
   logic [31:0]      arr_wdata;
   logic [31:0]      arr_rdata;
   logic             clearing;

   assign clearing = (state == ST_CLEAR) && !clr_cnt[IDX_W];

   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = ld_idx;
      arr_wbe   = bus.ld_be;
      arr_wdata = bus.ld_data;
      if (clearing) begin
         arr_we    = 1'b1;
         arr_waddr = clr_cnt[IDX_W-1:0];
         arr_wbe   = 4'hF;
         arr_wdata = '0;
      end else if (ld_fire && ld_ok) begin
         arr_we    = 1'b1;
      end
   end

`ifdef IMEM_PARITY_EN
   logic [3:0] arr_wpar, arr_rpar;
   logic       par_bad;
   // Injection inverts only the enabled bytes because only those are written.
   assign arr_wpar = clearing ? 4'h0
                              : (byte_parity(bus.ld_data) ^ {4{bus.inj_par_err}});
   assign par_bad  = |(byte_parity(arr_rdata) ^ arr_rpar);
`endif

   instr_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wbe   (arr_wbe),
      .wdata (arr_wdata),
`ifdef IMEM_PARITY_EN
      .wpar  (arr_wpar),
      .rpar  (arr_rpar),
`endif
      .raddr (req_idx),
      .rdata (arr_rdata)
   );

   // ---------------- fault priority: misalign > range > parity ----------------
   logic [1:0] fault_nxt;
   always_comb begin
      fault_nxt = FAULT_OK;
      if (req_misalign)   fault_nxt = FAULT_MISALIGN;
      else if (req_range) fault_nxt = FAULT_RANGE;
`ifdef IMEM_PARITY_EN
      else if (par_bad)   fault_nxt = FAULT_PARITY;
`endif
   end

   // ---------------- response register / loader error pulse ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         resp_instr_q <= NOP_INSTR;
         resp_fault_q <= FAULT_OK;
         ld_err_q     <= 1'b0;
      end else begin
         ld_err_q <= ld_fire && !ld_ok;
         if (req_fire) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= fault_nxt;
            resp_instr_q <= (fault_nxt == FAULT_OK) ? arr_rdata : NOP_INSTR;
         end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.init_done  = run;
   assign bus.ld_ready   = run;
   assign bus.req_ready  = run && (!resp_valid_q || bus.resp_ready);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_instr = resp_instr_q;
   assign bus.resp_fault = resp_fault_q;
   assign bus.ld_err     = ld_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_ctrl
// Description : Self-checking bench for instr_mem_ctrl (DEPTH_WORDS=64).
//               Table of load/fetch vectors plus hand-written sequences for
//               init timing, stall/back-pressure, same-cycle load/fetch and
//               mid-run reset. Parity sequence only when IMEM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_mem_ctrl_if #(.ADDR_W(32)) bus ();

   instr_mem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32),
      .NOP_INSTR   (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit          is_load;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [31:0] exp_instr;
      logic [1:0]  exp_fault;
      logic        exp_err;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.resp_ready = 1'b1;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_be      = '0;
      bus.ld_data    = '0;
`ifdef IMEM_PARITY_EN
      bus.inj_par_err = 1'b0;
`endif
   endtask

   // Counts rising edges from now until init_done is seen; also records
   // whether either ready was ever high before init_done.
   task automatic wait_init(input string name);
      int  edges = 0;
      bit  early = 1'b0;
      while (edges < 200) begin
         @(posedge clk); #1;
         edges++;
         if (bus.init_done === 1'b1) break;
         if (bus.req_ready !== 1'b0 || bus.ld_ready !== 1'b0) early = 1'b1;
      end
      check({name, ".init_edges"}, edges, 65);
      check({name, ".ready_early"}, 32'(early), 0);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input bit inj);
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = addr;
      bus.ld_be    = be;
      bus.ld_data  = data;
`ifdef IMEM_PARITY_EN
      bus.inj_par_err = inj;
`else
      if (inj) $display("note: parity injection ignored in this build");
`endif
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
`ifdef IMEM_PARITY_EN
      bus.inj_par_err = 1'b0;
`endif
   endtask

   task automatic do_fetch(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_instr, input logic [1:0] exp_fault);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_addr   = addr;
      bus.resp_ready = 1'b1;
      #1;
      check({name, ".req_ready"}, 32'(bus.req_ready), 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check({name, ".resp_valid"}, 32'(bus.resp_valid), 1);
      check({name, ".instr"}, bus.resp_instr, exp_instr);
      check({name, ".fault"}, 32'(bus.resp_fault), 32'(exp_fault));
   endtask

   initial begin
      // is_load addr           be     data           exp_instr      fault  err
      vecs[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_0000, 2'b00, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h1234_5678, 32'h0,         2'b00, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0008, 4'h4, 32'h00AB_0000, 32'h0,         2'b00, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'h12AB_5678, 2'b00, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0006, 4'h0, 32'h0,         NOP,           2'b01, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         NOP,           2'b10, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0102, 4'h0, 32'h0,         NOP,           2'b01, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0102, 4'hF, 32'hFFFF_FFFF, 32'h0,         2'b00, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_00C6, 4'hF, 32'hFFFF_FFFF, 32'h0,         2'b00, 1'b1};
      vecs[9]  = '{1'b0, 32'h0000_00C4, 4'h0, 32'h0,         32'h0000_0000, 2'b00, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000, 2'b00, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_00FC, 4'h1, 32'h0000_00A5, 32'h0,         2'b00, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_00FC, 4'h0, 32'h0,         32'h0000_00A5, 2'b00, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0,         2'b00, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_0000, 2'b00, 1'b0};
      vecs[15] = '{1'b0, 32'h8000_0000, 4'h0, 32'h0,         NOP,           2'b10, 1'b0};
      vecs[16] = '{1'b1, 32'h0000_0004, 4'h8, 32'hAA00_0000, 32'h0,         2'b00, 1'b0};
      vecs[17] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'hAA00_0000, 2'b00, 1'b0};
      vecs[18] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'h12AB_5678, 2'b00, 1'b0};
      vecs[19] = '{1'b1, 32'h1000_0008, 4'hF, 32'h5555_5555, 32'h0,         2'b00, 1'b1};
      vecs[20] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,         32'h12AB_5678, 2'b00, 1'b0};

      idle_inputs();

      // ---------- reset state and init timing ----------
      repeat (3) @(negedge clk);
      check("rst.init_done",  32'(bus.init_done),  0);
      check("rst.req_ready",  32'(bus.req_ready),  0);
      check("rst.ld_ready",   32'(bus.ld_ready),   0);
      check("rst.resp_valid", 32'(bus.resp_valid), 0);
      check("rst.resp_instr", bus.resp_instr,      NOP);
      check("rst.resp_fault", 32'(bus.resp_fault), 0);
      check("rst.ld_err",     32'(bus.ld_err),     0);
      reset = 1'b1;
      wait_init("boot");

      // ---------- table-driven vectors ----------
      for (int i = 0; i < 21; i++) begin
         if (vecs[i].is_load) begin
            do_load(vecs[i].addr, vecs[i].be, vecs[i].data, 1'b0);
            check($sformatf("vec%0d.ld_err", i), 32'(bus.ld_err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) begin
               @(posedge clk); #1;
               check($sformatf("vec%0d.ld_err_pulse", i), 32'(bus.ld_err), 0);
            end
         end else begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_fault);
         end
      end

      // ---------- back-pressure: 0x0,0x4,0x8 with 3 stalled cycles ----------
      do_load(32'h0, 4'hF, 32'h1111_1111, 1'b0);
      do_load(32'h4, 4'hF, 32'h2222_2222, 1'b0);
      do_load(32'h8, 4'hF, 32'h3333_3333, 1'b0);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h0;
      bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      check("bp.first_valid", 32'(bus.resp_valid), 1);
      check("bp.first_instr", bus.resp_instr, 32'h1111_1111);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.req_addr = 32'h4;
         check($sformatf("bp.stall%0d.req_ready", c), 32'(bus.req_ready), 0);
         @(posedge clk); #1;
         check($sformatf("bp.stall%0d.valid", c), 32'(bus.resp_valid), 1);
         check($sformatf("bp.stall%0d.instr", c), bus.resp_instr, 32'h1111_1111);
         check($sformatf("bp.stall%0d.fault", c), 32'(bus.resp_fault), 0);
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      #1;
      check("bp.release.req_ready", 32'(bus.req_ready), 1);
      @(posedge clk); #1;
      check("bp.second_valid", 32'(bus.resp_valid), 1);
      check("bp.second_instr", bus.resp_instr, 32'h2222_2222);
      @(negedge clk);
      bus.req_addr = 32'h8;
      @(posedge clk); #1;
      check("bp.third_valid", 32'(bus.resp_valid), 1);
      check("bp.third_instr", bus.resp_instr, 32'h3333_3333);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("bp.drain_valid", 32'(bus.resp_valid), 0);

      // ---------- same-cycle load and fetch of one word ----------
      @(negedge clk);
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 32'h20;
      bus.ld_be     = 4'hF;
      bus.ld_data   = 32'hCAFE_BABE;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h20;
      @(posedge clk); #1;
      bus.ld_valid  = 1'b0;
      bus.req_valid = 1'b0;
      check("rbw.old_instr", bus.resp_instr, 32'h0000_0000);
      do_fetch("rbw.new", 32'h20, 32'hCAFE_BABE, 2'b00);

      // ---------- reset mid-run with a pending response ----------
      do_load(32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h0;
      bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("mrst.pending_instr", bus.resp_instr, 32'hDEAD_BEEF);
      #2;
      reset = 1'b0;
      #1;
      check("mrst.resp_valid", 32'(bus.resp_valid), 0);
      check("mrst.init_done",  32'(bus.init_done),  0);
      check("mrst.req_ready",  32'(bus.req_ready),  0);
      check("mrst.resp_instr", bus.resp_instr,      NOP);
      @(negedge clk);
      bus.resp_ready = 1'b1;
      reset = 1'b1;
      wait_init("reboot");
      do_fetch("mrst.cleared", 32'h0, 32'h0000_0000, 2'b00);

`ifdef IMEM_PARITY_EN
      // ---------- parity injection and recovery ----------
      do_load(32'h0, 4'hF, 32'h1234_5678, 1'b1);
      do_fetch("par.inj", 32'h0, NOP, 2'b11);
      do_load(32'h0, 4'hF, 32'h1234_5678, 1'b0);
      do_fetch("par.clean", 32'h0, 32'h1234_5678, 2'b00);
      do_fetch("par.misalign_wins", 32'h2, NOP, 2'b01);
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
